// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: CH-channel PWM generator with double-buffered period/duty applied at period boundaries.
// Optional build macro PWM_SYNC_EN adds a sync_in port that restarts every enabled channel together.
module pwm_multi_gen #(
    parameter int CH         = 4,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 49,
    parameter int DEF_DUTY   = 25,
    localparam int CH_W      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk50,
    input  logic             rst_n,
`ifdef PWM_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic [CH-1:0]    en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_duty,
    output logic [CH-1:0]    pwm_out,
    output logic [CH-1:0]    period_tick,
    output logic [CH-1:0]    upd_pend
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] duty;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{period: CNT_W'(DEF_PERIOD), duty: CNT_W'(DEF_DUTY)};

    logic sync_w;

`ifdef PWM_SYNC_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        cfg_t             act_q, act_d;
        cfg_t             shd_q, shd_d;
        logic             pend_q, pend_d;
        logic             run_q;
        logic             pwm_q, pwm_d;
        logic             tick_q, tick_d;
        logic             wr_hit;
        logic             xfer;

        // An out-of-range wr_ch matches no channel, so the write is dropped.
        assign wr_hit = wr_en && (int'(wr_ch) == i);

        always_comb begin
            // NOTE: every signal driven here gets a default first so no latch is inferred.
            cnt_d  = cnt_q;
            act_d  = act_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            xfer   = 1'b0;

            if (!en[i]) begin
                cnt_d = '0;
                xfer  = 1'b1;
            end else if (sync_w || !run_q || (cnt_q == act_q.period)) begin
                // Restart: sync, first enabled cycle, or wrap by compare.
                cnt_d = '0;
                xfer  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            if (xfer) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end

            // A write in a transfer cycle lands in the shadow and stays pending.
            if (wr_hit) begin
                shd_d  = '{period: wr_period, duty: wr_duty};
                pend_d = 1'b1;
            end

            // NOTE: outputs use next-state cnt/active so the registered pwm/tick align with cnt.
            pwm_d  = en[i] && (cnt_d < act_d.duty);
            tick_d = en[i] && (cnt_d == act_d.period);
        end

        always_ff @(posedge clk50 or negedge rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (!rst_n) begin
                cnt_q  <= '0;
                act_q  <= DEF_CFG;
                shd_q  <= DEF_CFG;
                pend_q <= 1'b0;
                run_q  <= 1'b0;
                pwm_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                run_q  <= en[i];
                pwm_q  <= pwm_d;
                tick_q <= tick_d;
            end
        end

        assign pwm_out[i]     = pwm_q;
        assign period_tick[i] = tick_q;
        assign upd_pend[i]    = pend_q;
    end

endmodule
